// File: rtl/sdram_responder.sv
// sdram_responder
//   Avalon-MM memory endpoint standing in for SDRAM. It serves 32-bit word
//   reads with a fixed pipelined latency plus readdatavalid, and takes
//   single-cycle writes. Back-pressure comes from an outstanding-read limit
//   and an optional periodic one-cycle stall.
//
// Parameters
//   ADDR_W      word-index width (memory depth 2^ADDR_W words)
//   LATENCY     read latency in cycles, 1..8
//   MAX_PENDING maximum outstanding reads, >= 1
//   STALL_EVERY 0 = no stall; N>0 = one forced wait after every N accepts
//
// Ports
//   clk                  in   clock, rising edge
//   rst                  in   asynchronous active-high reset
//   slave_waitrequest    out  transfer not accepted this cycle
//   slave_address        in   byte address, word index = [ADDR_W+1:2]
//   slave_read           in   read request
//   slave_readdata       out  read data (0 when readdatavalid is low)
//   slave_readdatavalid  out  response valid
//   slave_write          in   write request
//   slave_writedata      in   write data
module sdram_responder #(
    parameter int ADDR_W      = 10,
    parameter int LATENCY     = 2,
    parameter int MAX_PENDING = 4,
    parameter int STALL_EVERY = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_dat [0:LATENCY-1];
    logic [LATENCY-1:0] r_vld;
    logic [PW-1:0]     r_pend;

    logic [ADDR_W-1:0] w_idx;
    logic              w_acc;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_rdv;
    logic              w_stall;
    logic              w_unused_addr;

    // Upper address bits select nothing: indices wrap modulo the depth.
    assign w_idx         = slave_address[ADDR_W+1:2];
    assign w_unused_addr = ^{slave_address[31:ADDR_W+2], slave_address[1:0]};

    assign w_rdv = r_vld[LATENCY-1];

    // Waitrequest uses registered state only (plus rst), so a master may
    // look at it before deciding whether to raise read/write. A full
    // pending count is forgiven on the cycle a response retires.
    assign slave_waitrequest = rst
                             | ((r_pend == PEND_MAX) & ~w_rdv)
                             | w_stall;

    assign w_acc    = (slave_read | slave_write) & ~slave_waitrequest;
    assign w_wr_acc = slave_write & ~slave_waitrequest;
    // A simultaneous read+write is a write only.
    assign w_rd_acc = slave_read & ~slave_write & ~slave_waitrequest;

    assign slave_readdatavalid = w_rdv;
    assign slave_readdata      = w_rdv ? r_dat[LATENCY-1] : 32'h0;

    // Memory and data pipeline carry no reset: contents persist across rst,
    // and stale pipeline data is hidden by the valid gating above. The
    // array is sampled at read accept, so later writes never leak into an
    // earlier read's response.
    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[w_idx] <= slave_writedata;
        if (w_rd_acc)
            r_dat[0] <= r_mem[w_idx];
        for (int k = 1; k < LATENCY; k++)
            r_dat[k] <= r_dat[k-1];
    end

    // Valid tokens: stage 0 loads at the accept edge, so the last stage
    // is high from edge E+LATENCY-1 to E+LATENCY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_acc;
            for (int k = 1; k < LATENCY; k++)
                r_vld[k] <= r_vld[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            case ({w_rd_acc, w_rdv})
                2'b10:   r_pend <= r_pend + 1'b1;
                2'b01:   r_pend <= r_pend - 1'b1;
                default: r_pend <= r_pend;
            endcase
        end
    end

    generate
        if (STALL_EVERY > 0) begin : g_stall
            localparam int SW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
            localparam logic [SW-1:0] LAST = SW'(STALL_EVERY - 1);

            logic [SW-1:0] r_scnt;
            logic          r_stall;

            // While r_stall is high nothing is accepted, so the flag lasts
            // exactly one cycle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_scnt  <= '0;
                    r_stall <= 1'b0;
                end else begin
                    r_stall <= 1'b0;
                    if (w_acc) begin
                        if (r_scnt == LAST) begin
                            r_scnt  <= '0;
                            r_stall <= 1'b1;
                        end else begin
                            r_scnt <= r_scnt + 1'b1;
                        end
                    end
                end
            end

            assign w_stall = r_stall;
        end else begin : g_nostall
            assign w_stall = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder. Four instances cover the parameter
// sets: u0 defaults, u1 LATENCY=3/MAX_PENDING=1, u2 STALL_EVERY=2,
// u3 LATENCY=4. A negedge monitor logs every response with the edge at
// which the master samples it.
module tb_sdram_responder;

    logic        clk = 1'b0;
    logic        rst   [4];
    logic        rd    [4];
    logic        wr    [4];
    logic        wreq  [4];
    logic        rdv   [4];
    logic [31:0] addr  [4];
    logic [31:0] wdat  [4];
    logic [31:0] rdat  [4];

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int zbad [4];

    typedef struct {
        int          d;
        int          at;
        logic [31:0] dat;
    } rsp_t;
    rsp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdram_responder #(.ADDR_W(10), .LATENCY(2), .MAX_PENDING(4), .STALL_EVERY(0)) u0 (
        .clk(clk), .rst(rst[0]), .slave_waitrequest(wreq[0]), .slave_address(addr[0]),
        .slave_read(rd[0]), .slave_readdata(rdat[0]), .slave_readdatavalid(rdv[0]),
        .slave_write(wr[0]), .slave_writedata(wdat[0]));
    sdram_responder #(.ADDR_W(10), .LATENCY(3), .MAX_PENDING(1), .STALL_EVERY(0)) u1 (
        .clk(clk), .rst(rst[1]), .slave_waitrequest(wreq[1]), .slave_address(addr[1]),
        .slave_read(rd[1]), .slave_readdata(rdat[1]), .slave_readdatavalid(rdv[1]),
        .slave_write(wr[1]), .slave_writedata(wdat[1]));
    sdram_responder #(.ADDR_W(10), .LATENCY(2), .MAX_PENDING(4), .STALL_EVERY(2)) u2 (
        .clk(clk), .rst(rst[2]), .slave_waitrequest(wreq[2]), .slave_address(addr[2]),
        .slave_read(rd[2]), .slave_readdata(rdat[2]), .slave_readdatavalid(rdv[2]),
        .slave_write(wr[2]), .slave_writedata(wdat[2]));
    sdram_responder #(.ADDR_W(10), .LATENCY(4), .MAX_PENDING(4), .STALL_EVERY(0)) u3 (
        .clk(clk), .rst(rst[3]), .slave_waitrequest(wreq[3]), .slave_address(addr[3]),
        .slave_read(rd[3]), .slave_readdata(rdat[3]), .slave_readdatavalid(rdv[3]),
        .slave_write(wr[3]), .slave_writedata(wdat[3]));

    // A response seen here is sampled by the master at edge cyc+1.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rdv[d]) begin
                rsp_t r;
                r.d   = d;
                r.at  = cyc + 1;
                r.dat = rdat[d];
                q.push_back(r);
            end else if (rdat[d] != 32'h0) begin
                zbad[d]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for the request on instance d to be accepted. Returns the
    // number of wait cycles and the accept edge; leaves time at edge+1.
    task automatic acc(input int d, output int waits, output int e);
        waits = 0;
        @(negedge clk);
        while (wreq[d] && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        if (wreq[d]) chk("acc_timeout", {31'b0, wreq[d]}, 32'h0);
        @(posedge clk); #1;
        e = cyc;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input int d, input logic [31:0] a, input logic [31:0] v);
        int w, e;
        addr[d] = a; wdat[d] = v; wr[d] = 1'b1;
        acc(d, w, e);
        wr[d] = 1'b0;
    endtask

    task automatic rd_chk(input int d, input string tag, input logic [31:0] a,
                          input logic [31:0] exp, input int lat, output int waits);
        int n0, e, cnt;
        n0 = q.size();
        addr[d] = a; rd[d] = 1'b1;
        acc(d, waits, e);
        rd[d] = 1'b0;
        step(lat + 3);
        cnt = 0;
        for (int i = n0; i < q.size(); i++) if (q[i].d == d) cnt++;
        chk({tag, "_cnt"}, cnt, 1);
        if (q.size() > n0) begin
            chk({tag, "_dat"}, q[n0].dat, exp);
            chk({tag, "_lat"}, q[n0].at - e, lat);
        end
    endtask

    initial begin
        int w, e, e0, e1, e2, n0, ws;
        int wv [4];
        for (int d = 0; d < 4; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdat[d] = '0; zbad[d] = 0;
        end

        // Reset state
        step(2);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("rst_wreq", {31'b0, wreq[d]}, 32'h1);
            chk("rst_rdv",  {31'b0, rdv[d]},  32'h0);
            chk("rst_rdat", rdat[d], 32'h0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) rst[d] = 1'b0;
        @(negedge clk);
        chk("post_rst_wreq", {31'b0, wreq[0]}, 32'h0);
        step(1);

        // Defaults: single write then read, latency 2
        addr[0] = 32'h10; wdat[0] = 32'hAAAA1110; wr[0] = 1'b1;
        acc(0, w, e);
        wr[0] = 1'b0;
        chk("t1_wr_wait", w, 0);
        rd_chk(0, "t1", 32'h10, 32'hAAAA1110, 2, w);
        chk("t1_rd_wait", w, 0);

        // Four back-to-back reads, no back-pressure
        for (int i = 0; i < 4; i++) wr_word(0, i * 4, i + 1);
        n0 = q.size(); ws = 0; e0 = 0;
        rd[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr[0] = i * 4;
            acc(0, w, e);
            ws += w;
            if (i == 0) e0 = e;
        end
        rd[0] = 1'b0;
        step(6);
        chk("t2_waits", ws, 0);
        chk("t2_cnt", q.size() - n0, 4);
        for (int i = 0; i < 4 && n0 + i < q.size(); i++) begin
            chk("t2_dat", q[n0+i].dat, i + 1);
            chk("t2_at", q[n0+i].at - e0, 2 + i);
        end

        // LATENCY=3, MAX_PENDING=1: second read held until first retires
        wr_word(1, 32'h0, 32'h11111111);
        wr_word(1, 32'h4, 32'h22222222);
        n0 = q.size();
        addr[1] = 32'h0; rd[1] = 1'b1;
        acc(1, w, e1);
        addr[1] = 32'h4;
        acc(1, w, e2);
        rd[1] = 1'b0;
        chk("t3_waits", w, 2);
        chk("t3_gap", e2 - e1, 3);
        step(6);
        chk("t3_cnt", q.size() - n0, 2);
        if (q.size() >= n0 + 2) begin
            chk("t3_dat0", q[n0].dat, 32'h11111111);
            chk("t3_at0", q[n0].at - e1, 3);
            chk("t3_dat1", q[n0+1].dat, 32'h22222222);
            chk("t3_at1", q[n0+1].at - e2, 3);
        end

        // STALL_EVERY=2: one wait cycle after the 2nd and 4th accepts
        wr[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr[2] = i * 4; wdat[2] = 32'hC0DE0000 + i;
            acc(2, wv[i], e);
        end
        wr[2] = 1'b0;
        @(negedge clk);
        chk("t4_stall4", {31'b0, wreq[2]}, 32'h1);
        @(negedge clk);
        chk("t4_stall4_end", {31'b0, wreq[2]}, 32'h0);
        chk("t4_w0", wv[0], 0);
        chk("t4_w1", wv[1], 0);
        chk("t4_w2", wv[2], 1);
        chk("t4_w3", wv[3], 0);
        step(1);
        for (int i = 0; i < 4; i++) rd_chk(2, "t4_rd", i * 4, 32'hC0DE0000 + i, 2, w);

        // Reset mid-read drops in-flight reads, memory persists
        wr_word(3, 32'h40, 32'hBEEF0001);
        n0 = q.size();
        addr[3] = 32'h40; rd[3] = 1'b1;
        acc(3, w, e);
        addr[3] = 32'h44;
        acc(3, w, e);
        rd[3] = 1'b0;
        step(1);
        rst[3] = 1'b1;
        @(negedge clk);
        chk("t5_rst_wreq", {31'b0, wreq[3]}, 32'h1);
        @(posedge clk); #1;
        rst[3] = 1'b0;
        step(8);
        n0 = q.size() - n0;
        chk("t5_dropped", n0, 0);
        rd_chk(3, "t5_old", 32'h40, 32'hBEEF0001, 4, w);

        // Simultaneous read+write is write-only; address wraps
        n0 = q.size();
        addr[0] = 32'h20; wdat[0] = 32'h5A5A5A5A; rd[0] = 1'b1; wr[0] = 1'b1;
        acc(0, w, e);
        rd[0] = 1'b0; wr[0] = 1'b0;
        step(5);
        chk("t6_no_rsp", q.size() - n0, 0);
        rd_chk(0, "t6_wrap", 32'h1020, 32'h5A5A5A5A, 2, w);

        for (int d = 0; d < 4; d++) chk("rdat_zero", zbad[d], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Avalon-MM memory responder: the SDRAM-side endpoint that answers the accelerator's master port (word copy / DNN engines). It serves word reads with a fixed pipelined latency and `readdatavalid`, accepts single-cycle writes, and exerts programmable `waitrequest` back-pressure through an outstanding-read limit and a periodic stall. It stands in for SDRAM in simulation and serves as on-chip scratch memory in small builds.

## Interface
- `ADDR_W`, 10: word-index width; memory holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: read latency in cycles, legal range 1..8.
- `MAX_PENDING`, 4: maximum outstanding reads, at least 1.
- `STALL_EVERY`, 0: 0 disables the periodic stall; N>0 inserts one forced wait cycle after every N accepted transfers.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `slave_waitrequest` out 1: transfer not accepted this cycle.
- `slave_address` in 32: byte address; word index = `[ADDR_W+1:2]`, all other bits ignored.
- `slave_read` in 1: read request.
- `slave_readdata` out 32: read data.
- `slave_readdatavalid` out 1: `slave_readdata` holds a response.
- `slave_write` in 1: write request.
- `slave_writedata` in 32: write data.

## Operation
- A transfer is accepted at a rising edge when (`slave_read` | `slave_write`) & !`slave_waitrequest`.
- Write accept: `mem[index] <= slave_writedata` at that edge. No response.
- Read accept: index and a valid token enter a `LATENCY`-stage pipeline. Responses return in acceptance order.
- Read and write asserted together: treated as a write only. No read response is generated.
- Address wrap: indices are taken modulo 2^ADDR_W, so byte address 4·2^ADDR_W aliases word 0.
- Pending counter: +1 on read accept, −1 on a cycle with `readdatavalid`, net 0 when both occur. Never exceeds `MAX_PENDING`.
- `slave_waitrequest` = `rst` | (pending == MAX_PENDING & !slave_readdatavalid) | stall_flag. It depends only on registered state, never on `slave_read`/`slave_write`.
- Stall: an accepted-transfer counter (reads and writes) counts modulo `STALL_EVERY`. When it wraps, stall_flag is set for exactly the next cycle.
- Memory contents are not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: `slave_readdatavalid`=0, `slave_readdata`=0, `slave_waitrequest`=1 while `rst` is high. Pipeline tokens, pending counter, stall counter and stall_flag are all cleared.
- Read latency: a read accepted at edge E drives `readdatavalid`=1 and the data from edge E+LATENCY−1 to edge E+LATENCY. The master samples it at edge E+LATENCY. With LATENCY=1 this is a plain synchronous RAM read.
- `slave_readdata` is 0 whenever `readdatavalid` is 0.
- Read-after-write: a write accepted at edge E is visible to any read accepted at edge E+1 or later. A read and write to the same index at the same edge is impossible, because simultaneous requests are treated as write-only.
- Throughput: back-to-back reads run at one per cycle when MAX_PENDING ≥ LATENCY. When pending is full, a new read is accepted at the same edge a response retires.
- Reset mid-operation: in-flight reads are dropped, and no `readdatavalid` is produced after `rst` rises. Writes completed before reset persist.
- Requests held while `waitrequest`=1 are not consumed. The master keeps address and data stable until acceptance.

## Test plan
- Defaults. Write 0xAAAA1110 to byte address 0x10, then read 0x10. Response: accepted with no wait, `readdatavalid` sampled exactly 2 edges after read accept, data 0xAAAA1110, `readdata`=0 in all other cycles.
- LATENCY=2, MAX_PENDING=4. Write words 0x1..0x4 to addresses 0x0,0x4,0x8,0xC, then issue 4 back-to-back reads. Response: `waitrequest` never asserted, and 4 consecutive `readdatavalid` cycles returning 0x1,0x2,0x3,0x4 in order.
- LATENCY=3, MAX_PENDING=1. Hold two reads. Response: the second read waits with `waitrequest`=1 and is accepted at the edge the first response is sampled, 3 edges after the first accept. Both data values are correct.
- STALL_EVERY=2. Stream 4 writes with write held continuously. Response: `waitrequest` high for exactly one cycle after the 2nd and 4th accepts, and all 4 words read back correctly.
- Reset mid-read. Issue 2 reads with LATENCY=4, then pulse `rst` one cycle later. Response: no `readdatavalid` ever appears for them, and `waitrequest`=1 during `rst`. A later read of a word written before reset returns the old data.
- Simultaneous read and write to 0x20 with data 0x5A5A5A5A. Response: no read response. A later read of address 4·2^ADDR_W+0x20 returns 0x5A5A5A5A, confirming the wrap.
